// File: rtl/mcso_pkg.sv
// mcso_pkg: definitions shared by the multi-channel serial output block.
//   Command op encodings, controller state encodings, default parameter
//   values and a small constant helper for sizing the bit-period counter.
package mcso_pkg;

    typedef logic [1:0] cmd_op_t;

    localparam cmd_op_t OP_LOAD   = 2'b00;
    localparam cmd_op_t OP_COMMIT = 2'b01;
    localparam cmd_op_t OP_STOP   = 2'b10;
    localparam cmd_op_t OP_NOP    = 2'b11;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    localparam int DEF_DATA_BIT = 32;
    localparam int DEF_CH_NUM   = 3;
    localparam int DEF_SLOW_DIV = 4;
    localparam int DEF_FAST_DIV = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_chan.sv
// serial_chan: one serial output channel.
//   Holds a shadow copy of (pattern, freq, mode) written by load, copied into
//   the active copy on start or at the end of a repeat pass. Shifts LSB
//   first; each bit lasts FAST_DIV clocks when its freq bit is 1, else
//   SLOW_DIV clocks, timed by a down-counter that ends the bit at zero.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load, load_output,
//   load_freq, load_mode     shadow write strobe and data
//   start                    (re)start from bit 0 with the shadow contents
//   stop                     abort to idle, no done pulse
//   serial_out               current bit, low when idle
//   bit_tick, done_tick      one-clock pulses at bit end / pass end
//   busy                     channel is shifting
module serial_chan
    import mcso_pkg::*;
#(
    parameter int DATA_BIT = DEF_DATA_BIT,
    parameter int SLOW_DIV = DEF_SLOW_DIV,
    parameter int FAST_DIV = DEF_FAST_DIV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [DATA_BIT-1:0] load_output,
    input  logic [DATA_BIT-1:0] load_freq,
    input  logic                load_mode,
    input  logic                start,
    input  logic                stop,
    output logic                serial_out,
    output logic                bit_tick,
    output logic                done_tick,
    output logic                busy
);
    localparam int CNT_W = $clog2(max_int(SLOW_DIV, FAST_DIV) + 1);
    localparam int IDX_W = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam logic [CNT_W-1:0] SLOW_LOAD = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_LOAD = CNT_W'(FAST_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BIT - 1);

    logic [DATA_BIT-1:0] shadow_output;
    logic [DATA_BIT-1:0] shadow_freq;
    logic                shadow_mode;
    logic [DATA_BIT-1:0] active_output;
    logic [DATA_BIT-1:0] active_freq;
    logic                active_mode;
    logic [IDX_W-1:0]    bit_idx;
    logic [CNT_W-1:0]    bit_cnt;

    // Counter preload: the bit ends on the clock the counter is seen at zero.
    function automatic logic [CNT_W-1:0] period(input logic fast);
        return fast ? FAST_LOAD : SLOW_LOAD;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_output <= '0;
            shadow_freq   <= '0;
            shadow_mode   <= 1'b0;
            active_output <= '0;
            active_freq   <= '0;
            active_mode   <= 1'b0;
            bit_idx       <= '0;
            bit_cnt       <= '0;
            serial_out    <= 1'b0;
            bit_tick      <= 1'b0;
            done_tick     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            bit_tick  <= 1'b0;
            done_tick <= 1'b0;
            // Shadow is independent of the running pass; start/reload below
            // read the value from before this edge.
            if (load) begin
                shadow_output <= load_output;
                shadow_freq   <= load_freq;
                shadow_mode   <= load_mode;
            end
            if (stop) begin
                busy       <= 1'b0;
                serial_out <= 1'b0;
            end else if (start) begin
                active_output <= shadow_output;
                active_freq   <= shadow_freq;
                active_mode   <= shadow_mode;
                bit_idx       <= '0;
                bit_cnt       <= period(shadow_freq[0]);
                serial_out    <= shadow_output[0];
                busy          <= 1'b1;
            end else if (busy) begin
                if (bit_cnt != '0) begin
                    bit_cnt <= bit_cnt - CNT_W'(1);
                end else begin
                    bit_tick <= 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        done_tick <= 1'b1;
                        if (active_mode) begin
                            // Repeat: next pass begins on this same edge, no gap.
                            active_output <= shadow_output;
                            active_freq   <= shadow_freq;
                            active_mode   <= shadow_mode;
                            bit_idx       <= '0;
                            bit_cnt       <= period(shadow_freq[0]);
                            serial_out    <= shadow_output[0];
                        end else begin
                            busy       <= 1'b0;
                            serial_out <= 1'b0;
                        end
                    end else begin
                        bit_idx       <= bit_idx + IDX_W'(1);
                        active_output <= active_output >> 1;
                        active_freq   <= active_freq >> 1;
                        serial_out    <= active_output[1];
                        bit_cnt       <= period(active_freq[1]);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/multi_chan_serial_out.sv
// multi_chan_serial_out: command-driven bank of CH_NUM serial pattern outputs.
//   A two-state controller accepts one command, spends one clock in S_EXEC,
//   and turns it into registered per-channel load/start/stop pulses.
//   Optional feature macro MCSO_SEL_ERR_EN adds sticky o_err, set by a LOAD
//   whose channel select is out of range; without it such LOADs are ignored.
//
//   state  | meaning
//   S_IDLE | ready for a command
//   S_EXEC | one clock while the accepted command takes effect
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready    command handshake
//   i_cmd_op                     00 LOAD, 01 COMMIT, 10 STOP, 11 no-op
//   i_cmd_sel                    LOAD target channel
//   i_cmd_mask                   COMMIT/STOP channel mask
//   i_cmd_output, i_cmd_freq,
//   i_cmd_mode                   LOAD pattern, per-bit speed, repeat flag
//   o_serial_out, o_bit_tick,
//   o_done_tick, o_busy          per-channel outputs
//   o_err                        sticky bad-select flag (MCSO_SEL_ERR_EN only)
module multi_chan_serial_out
    import mcso_pkg::*;
#(
    parameter int DATA_BIT = DEF_DATA_BIT,
    parameter int CH_NUM   = DEF_CH_NUM,
    parameter int SLOW_DIV = DEF_SLOW_DIV,
    parameter int FAST_DIV = DEF_FAST_DIV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [1:0]          i_cmd_op,
    input  logic [3:0]          i_cmd_sel,
    input  logic [CH_NUM-1:0]   i_cmd_mask,
    input  logic [DATA_BIT-1:0] i_cmd_output,
    input  logic [DATA_BIT-1:0] i_cmd_freq,
    input  logic                i_cmd_mode,
    output logic [CH_NUM-1:0]   o_serial_out,
    output logic [CH_NUM-1:0]   o_bit_tick,
    output logic [CH_NUM-1:0]   o_done_tick,
    output logic [CH_NUM-1:0]   o_busy
`ifdef MCSO_SEL_ERR_EN
    ,
    output logic                o_err
`endif
);
    logic [0:0]          state;
    logic                accept;
    logic [CH_NUM-1:0]   load_pulse;
    logic [CH_NUM-1:0]   start_pulse;
    logic [CH_NUM-1:0]   stop_pulse;
    logic [DATA_BIT-1:0] cmd_output_q;
    logic [DATA_BIT-1:0] cmd_freq_q;
    logic                cmd_mode_q;

    // Ready is held low for the whole reset, not only after the first edge.
    assign o_cmd_ready = (state == S_IDLE) && !rst;
    assign accept      = i_cmd_valid && o_cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            load_pulse   <= '0;
            start_pulse  <= '0;
            stop_pulse   <= '0;
            cmd_output_q <= '0;
            cmd_freq_q   <= '0;
            cmd_mode_q   <= 1'b0;
        end else begin
            load_pulse  <= '0;
            start_pulse <= '0;
            stop_pulse  <= '0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_EXEC;
                        case (i_cmd_op)
                            OP_LOAD: begin
                                // Out-of-range select matches no channel.
                                for (int c = 0; c < CH_NUM; c++) begin
                                    load_pulse[c] <= (i_cmd_sel == 4'(c));
                                end
                                cmd_output_q <= i_cmd_output;
                                cmd_freq_q   <= i_cmd_freq;
                                cmd_mode_q   <= i_cmd_mode;
                            end
                            OP_COMMIT: start_pulse <= i_cmd_mask;
                            OP_STOP:   stop_pulse  <= i_cmd_mask;
                            default:   ;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MCSO_SEL_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err <= 1'b0;
        end else if (accept && (i_cmd_op == OP_LOAD)
                     && ({1'b0, i_cmd_sel} >= 5'(CH_NUM))) begin
            o_err <= 1'b1;
        end
    end
`endif

    for (genvar c = 0; c < CH_NUM; c++) begin : g_chan
        serial_chan #(
            .DATA_BIT (DATA_BIT),
            .SLOW_DIV (SLOW_DIV),
            .FAST_DIV (FAST_DIV)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .load        (load_pulse[c]),
            .load_output (cmd_output_q),
            .load_freq   (cmd_freq_q),
            .load_mode   (cmd_mode_q),
            .start       (start_pulse[c]),
            .stop        (stop_pulse[c]),
            .serial_out  (o_serial_out[c]),
            .bit_tick    (o_bit_tick[c]),
            .done_tick   (o_done_tick[c]),
            .busy        (o_busy[c])
        );
    end

endmodule

// File: tb/tb_multi_chan_serial_out.sv
// Testbench for multi_chan_serial_out: directed command sequences, a
// pattern-level reference model checked every cycle, and literal checks of
// the pass lengths and bit values worked out by hand.
module tb_multi_chan_serial_out;
    localparam int DB = 32;
    localparam int CH = 3;
    localparam int SD = 4;
    localparam int FD = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [1:0]    i_cmd_op;
    logic [3:0]    i_cmd_sel;
    logic [CH-1:0] i_cmd_mask;
    logic [DB-1:0] i_cmd_output;
    logic [DB-1:0] i_cmd_freq;
    logic          i_cmd_mode;
    logic [CH-1:0] o_serial_out;
    logic [CH-1:0] o_bit_tick;
    logic [CH-1:0] o_done_tick;
    logic [CH-1:0] o_busy;
`ifdef MCSO_SEL_ERR_EN
    logic          o_err;
`endif

    multi_chan_serial_out #(
        .DATA_BIT (DB),
        .CH_NUM   (CH),
        .SLOW_DIV (SD),
        .FAST_DIV (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_op     (i_cmd_op),
        .i_cmd_sel    (i_cmd_sel),
        .i_cmd_mask   (i_cmd_mask),
        .i_cmd_output (i_cmd_output),
        .i_cmd_freq   (i_cmd_freq),
        .i_cmd_mode   (i_cmd_mode),
        .o_serial_out (o_serial_out),
        .o_bit_tick   (o_bit_tick),
        .o_done_tick  (o_done_tick),
        .o_busy       (o_busy)
`ifdef MCSO_SEL_ERR_EN
        ,
        .o_err        (o_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int dur(input logic f);
        return f ? FD : SD;
    endfunction

    function automatic int pass_len(input logic [DB-1:0] fr);
        int s = 0;
        for (int b = 0; b < DB; b++) s += dur(fr[b]);
        return s;
    endfunction

    function automatic int bit_at(input logic [DB-1:0] fr, input int k);
        int acc = 0;
        for (int b = 0; b < DB; b++) begin
            acc += dur(fr[b]);
            if (k < acc) return b;
        end
        return DB - 1;
    endfunction

    function automatic bit is_boundary(input logic [DB-1:0] fr, input int k);
        int acc = 0;
        for (int b = 0; b < DB - 1; b++) begin
            acc += dur(fr[b]);
            if (acc == k) return 1'b1;
        end
        return 1'b0;
    endfunction

    logic [DB-1:0] sh_out [CH];
    logic [DB-1:0] sh_fr  [CH];
    logic          sh_md  [CH];
    logic [DB-1:0] a_out  [CH];
    logic [DB-1:0] a_fr   [CH];
    logic          a_md   [CH];
    logic          run    [CH];
    int            st     [CH];
    int            p_load;
    logic [DB-1:0] p_out, p_fr;
    logic          p_md;
    logic [CH-1:0] p_start, p_stop;
    logic          m_exec, m_err, model_on;
    logic [CH-1:0] e_ser, e_bt, e_dt, e_busy;
    int            cyc = 0;
    int            mk;

    initial model_on = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                sh_out[c] = '0; sh_fr[c] = '0; sh_md[c] = 1'b0;
                a_out[c] = '0; a_fr[c] = '0; a_md[c] = 1'b0;
                run[c] = 1'b0; st[c] = 0;
            end
            p_load = -1; p_out = '0; p_fr = '0; p_md = 1'b0;
            p_start = '0; p_stop = '0;
            m_exec = 1'b0; m_err = 1'b0;
            e_ser = '0; e_bt = '0; e_dt = '0; e_busy = '0;
            model_on = 1'b1;
        end else begin
            for (int c = 0; c < CH; c++) begin
                e_bt[c] = 1'b0;
                e_dt[c] = 1'b0;
                if (p_stop[c]) begin
                    run[c] = 1'b0;
                end else if (p_start[c]) begin
                    a_out[c] = sh_out[c]; a_fr[c] = sh_fr[c]; a_md[c] = sh_md[c];
                    st[c] = cyc; run[c] = 1'b1;
                end else if (run[c]) begin
                    mk = cyc - st[c];
                    if (mk == pass_len(a_fr[c])) begin
                        e_bt[c] = 1'b1;
                        e_dt[c] = 1'b1;
                        if (a_md[c]) begin
                            a_out[c] = sh_out[c]; a_fr[c] = sh_fr[c]; a_md[c] = sh_md[c];
                            st[c] = cyc;
                        end else begin
                            run[c] = 1'b0;
                        end
                    end else if (is_boundary(a_fr[c], mk)) begin
                        e_bt[c] = 1'b1;
                    end
                end
                e_busy[c] = run[c];
                e_ser[c]  = run[c] ? a_out[c][bit_at(a_fr[c], cyc - st[c])] : 1'b0;
            end
            if (p_load >= 0) begin
                sh_out[p_load] = p_out; sh_fr[p_load] = p_fr; sh_md[p_load] = p_md;
            end
            p_load = -1; p_start = '0; p_stop = '0;
            if (m_exec) begin
                m_exec = 1'b0;
            end else if (i_cmd_valid) begin
                m_exec = 1'b1;
                case (i_cmd_op)
                    2'b00: begin
                        if (int'(i_cmd_sel) < CH) begin
                            p_load = int'(i_cmd_sel);
                            p_out = i_cmd_output; p_fr = i_cmd_freq; p_md = i_cmd_mode;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                    2'b01:   p_start = i_cmd_mask;
                    2'b10:   p_stop  = i_cmd_mask;
                    default: ;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_on) begin
            chk("cmd_ready",  64'(o_cmd_ready),  64'(!m_exec && !rst));
            chk("serial_out", 64'(o_serial_out), 64'(e_ser));
            chk("busy",       64'(o_busy),       64'(e_busy));
            chk("bit_tick",   64'(o_bit_tick),   64'(e_bt));
            chk("done_tick",  64'(o_done_tick),  64'(e_dt));
`ifdef MCSO_SEL_ERR_EN
            chk("err",        64'(o_err),        64'(m_err));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cmd(input logic [1:0] op, input logic [3:0] sel,
                       input logic [CH-1:0] mask, input logic [DB-1:0] o,
                       input logic [DB-1:0] f, input logic md);
        int tries = 0;
        while (!o_cmd_ready && tries < 10) begin
            @(negedge clk);
            tries++;
        end
        if (!o_cmd_ready) begin
            chk("cmd_ready_timeout", 64'(o_cmd_ready), 64'd1);
            return;
        end
        i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_sel = sel; i_cmd_mask = mask;
        i_cmd_output = o; i_cmd_freq = f; i_cmd_mode = md;
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    // Counts negedges from the current one until done_tick[ch] is seen.
    task automatic wait_done(input int ch, input int k0, output int k);
        k = k0;
        while (!o_done_tick[ch] && k < 400) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int k;
        rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_op = 2'b00; i_cmd_sel = 4'd0;
        i_cmd_mask = '0; i_cmd_output = '0; i_cmd_freq = '0; i_cmd_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready",  64'(o_cmd_ready),  64'd0);
        chk("rst_serial", 64'(o_serial_out), 64'd0);
        chk("rst_busy",   64'(o_busy),       64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(o_cmd_ready), 64'd1);

        // One-shot 0x5, all slow: 1,0,1 then zeros, 4 clocks each, 128 total.
        cmd(2'b00, 4'd0, '0, 32'h0000_0005, 32'h0, 1'b0);
        cmd(2'b01, 4'd0, 3'b001, '0, '0, 1'b0);
        @(negedge clk);
        chk("a_bit0", 64'(o_serial_out[0]), 64'd1);
        chk("a_busy", 64'(o_busy[0]), 64'd1);
        repeat (4) @(negedge clk);
        chk("a_bit1", 64'(o_serial_out[0]), 64'd0);
        repeat (4) @(negedge clk);
        chk("a_bit2", 64'(o_serial_out[0]), 64'd1);
        repeat (4) @(negedge clk);
        chk("a_bit3", 64'(o_serial_out[0]), 64'd0);
        wait_done(0, 12, k);
        chk("a_pass_len", 64'(k), 64'd128);
        chk("a_idle_serial", 64'(o_serial_out[0]), 64'd0);
        chk("a_idle_busy", 64'(o_busy[0]), 64'd0);

        // Three channels started together; bit0 = 1,0,1 and aligned ticks.
        cmd(2'b00, 4'd0, '0, 32'h1234_5671, 32'h0, 1'b0);
        cmd(2'b00, 4'd1, '0, 32'h0000_00F0, 32'h0, 1'b0);
        cmd(2'b00, 4'd2, '0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        cmd(2'b01, 4'd0, 3'b111, '0, '0, 1'b0);
        @(negedge clk);
        chk("b_bit0_all", 64'(o_serial_out), 64'b101);
        chk("b_busy_all", 64'(o_busy), 64'b111);
        repeat (4) @(negedge clk);
        chk("b_tick_aligned", 64'(o_bit_tick), 64'b111);
        cmd(2'b01, 4'd0, 3'b001, '0, '0, 1'b0);
        repeat (6) @(negedge clk);
        cmd(2'b10, 4'd0, 3'b111, '0, '0, 1'b0);
        repeat (2) @(negedge clk);

        // Mixed speed: 16 slow bits + 16 fast bits = 80 clocks.
        cmd(2'b00, 4'd1, '0, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0);
        cmd(2'b01, 4'd0, 3'b010, '0, '0, 1'b0);
        @(negedge clk);
        chk("c_bit0", 64'(o_serial_out[1]), 64'd1);
        wait_done(1, 0, k);
        chk("c_pass_len", 64'(k), 64'd80);

        // Repeat on ch2, new pattern loaded mid-pass takes over with no gap.
        cmd(2'b00, 4'd2, '0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        cmd(2'b01, 4'd0, 3'b100, '0, '0, 1'b0);
        @(negedge clk);
        chk("d_bit0_old", 64'(o_serial_out[2]), 64'd0);
        repeat (10) @(negedge clk);
        cmd(2'b00, 4'd2, '0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        wait_done(2, 11, k);
        chk("d_pass1_len", 64'(k), 64'd32);
        chk("d_bit0_new", 64'(o_serial_out[2]), 64'd1);
        chk("d_busy_cont", 64'(o_busy[2]), 64'd1);
        @(negedge clk);
        wait_done(2, 1, k);
        chk("d_pass2_len", 64'(k), 64'd32);
        cmd(2'b10, 4'd0, 3'b100, '0, '0, 1'b0);
        repeat (2) @(negedge clk);

        // STOP mid-pass: idle two clocks after the command, no done pulse.
        cmd(2'b00, 4'd1, '0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        cmd(2'b01, 4'd0, 3'b010, '0, '0, 1'b0);
        repeat (10) @(negedge clk);
        cmd(2'b10, 4'd0, 3'b010, '0, '0, 1'b0);
        chk("e_busy_before", 64'(o_busy[1]), 64'd1);
        @(negedge clk);
        chk("e_serial_stopped", 64'(o_serial_out[1]), 64'd0);
        chk("e_busy_stopped", 64'(o_busy[1]), 64'd0);
        chk("e_no_done", 64'(o_done_tick[1]), 64'd0);

        // Reset mid-pass.
        cmd(2'b00, 4'd0, '0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        cmd(2'b01, 4'd0, 3'b001, '0, '0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("r_serial", 64'(o_serial_out), 64'd0);
        chk("r_busy",   64'(o_busy), 64'd0);
        chk("r_done",   64'(o_done_tick), 64'd0);
        chk("r_ready",  64'(o_cmd_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("r_ready_after", 64'(o_cmd_ready), 64'd1);

        // Out-of-range select and reserved op change nothing.
        cmd(2'b00, 4'd0, '0, 32'h0000_0003, 32'h0, 1'b0);
        cmd(2'b00, 4'd5, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        cmd(2'b11, 4'd1, 3'b111, 32'hFFFF_FFFF, 32'h0, 1'b1);
        cmd(2'b01, 4'd0, 3'b111, '0, '0, 1'b0);
        @(negedge clk);
        chk("f_bit0", 64'(o_serial_out), 64'b001);
`ifdef MCSO_SEL_ERR_EN
        chk("f_err", 64'(o_err), 64'd1);
`endif
        repeat (4) @(negedge clk);
        chk("f_bit1", 64'(o_serial_out), 64'b001);
        cmd(2'b10, 4'd0, 3'b111, '0, '0, 1'b0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multi_chan_serial_out.md
MULTI_CHAN_SERIAL_OUT -- requirements
Module: multi_chan_serial_out

Interface
REQ-001 SHALL have parameter DATA_BIT, default 32, pattern width in bits.
REQ-002 SHALL have parameter CH_NUM, default 3, channel count (1..16).
REQ-003 SHALL have parameter SLOW_DIV, default 4, clocks per bit when the freq bit is 0 (>=1).
REQ-004 SHALL have parameter FAST_DIV, default 1, clocks per bit when the freq bit is 1 (>=1).
REQ-005 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_cmd_valid  in  1  command present.
REQ-008 SHALL have port o_cmd_ready  out  1  command accepted when valid&ready.
REQ-009 SHALL have port i_cmd_op  in  2  00 LOAD, 01 COMMIT, 10 STOP, 11 reserved (no-op).
REQ-010 SHALL have port i_cmd_sel  in  4  target channel for LOAD.
REQ-011 SHALL have port i_cmd_mask  in  CH_NUM  channel mask for COMMIT/STOP.
REQ-012 SHALL have port i_cmd_output  in  DATA_BIT  output pattern for LOAD.
REQ-013 SHALL have port i_cmd_freq  in  DATA_BIT  per-bit frequency pattern for LOAD.
REQ-014 SHALL have port i_cmd_mode  in  1  LOAD mode: 0 one-shot, 1 repeat.
REQ-015 SHALL have port o_serial_out  out  CH_NUM  serial data per channel, idle low.
REQ-016 SHALL have port o_bit_tick  out  CH_NUM  one-clock pulse per channel at each bit-period end.
REQ-017 SHALL have port o_done_tick  out  CH_NUM  one-clock pulse per channel at each pass end.
REQ-018 SHALL have port o_busy  out  CH_NUM  channel actively shifting.

Function
REQ-019 Controller FSM SHALL have states S_IDLE, S_EXEC; o_cmd_ready=1 only in S_IDLE; accept -> S_EXEC for one clock -> S_IDLE.
REQ-020 LOAD SHALL write output, freq, mode into shadow registers of channel i_cmd_sel, visible one clock after acceptance.
REQ-021 COMMIT SHALL issue one registered start pulse simultaneously to every masked channel one clock after acceptance; bit 0 appears on o_serial_out the following clock.
REQ-022 STOP SHALL force masked channels idle one clock after acceptance; o_serial_out low, o_busy low, no o_done_tick.
REQ-023 Each channel SHALL copy shadow into active registers on start, shift LSB first, holding each bit FAST_DIV clocks if its freq bit is 1, else SLOW_DIV clocks.
REQ-024 At the end of bit DATA_BIT-1: one-shot -> idle, output low, o_done_tick=1; repeat -> o_done_tick=1, reload active from shadow, continue with bit 0 the next clock without gap.
REQ-025 LOAD to a busy channel SHALL change only the shadow; the active pass is unaffected.
REQ-026 COMMIT to a busy channel SHALL restart it from bit 0 with current shadow contents.
REQ-027 LOAD with i_cmd_sel>=CH_NUM and op 11 SHALL change no state but still be accepted.
REQ-028 Bit-period counter SHALL be $clog2(max(SLOW_DIV,FAST_DIV)+1) bits wide and SHALL never wrap within a bit.

Reset
REQ-029 While rst=1: FSM to S_IDLE, all shadow/active registers 0, o_serial_out=0, o_bit_tick=0, o_done_tick=0, o_busy=0, o_cmd_ready=0; o_cmd_ready=1 the first clock after rst falls.
REQ-030 Reset mid-pass SHALL abort all channels with no o_done_tick.

Configuration
REQ-031 With macro MCSO_SEL_ERR_EN defined, a LOAD with i_cmd_sel>=CH_NUM SHALL set a sticky output o_err (1 bit, cleared only by rst); without it, o_err SHALL not exist and such LOADs are silently ignored.

Structure
REQ-032 Op encodings, state encodings and default divider values SHALL live in shared package mcso_pkg.
REQ-033 One per-channel sub-module serial_chan (shadow, active, bit index, divider, ticks) SHALL be instantiated CH_NUM times via generate.

Verification
REQ-034 LOAD ch0 output=0x0000_0005, freq=0, one-shot; COMMIT mask=001 -> o_serial_out[0] = 1,0,1 then 29 zeros, each 4 clocks; one o_done_tick after 128 clocks.
REQ-035 LOAD ch0..2 different patterns, COMMIT mask=111 -> all three bit-0 values appear on the same clock; bit ticks aligned.
REQ-036 LOAD ch1 freq=0xFFFF_0000 -> bits 0-15 last 4 clocks, bits 16-31 last 1 clock; pass length 80 clocks.
REQ-037 Repeat mode ch2 with LOAD of new pattern mid-pass -> old pattern completes, new starts with no gap clock; o_done_tick each pass.
REQ-038 STOP mask=010 mid-pass -> o_serial_out[1]=0 and o_busy[1]=0 two clocks after command, no o_done_tick; rst mid-pass -> all outputs 0.
REQ-039 LOAD sel=5 with CH_NUM=3 -> no channel changes; o_err=1 only when MCSO_SEL_ERR_EN defined.
